// File: rtl/paddle_pos_pkg.sv
// Shared game package: playfield geometry and the legal paddle top-line range
// derived from it.
package paddle_pos_pkg;

  localparam int LINE_COUNT    = 480;
  localparam int PADDLE_HEIGHT = 64;
  localparam int BORDER        = 8;

  // The paddle top line may sit just below the top border and no lower than
  // one paddle height plus the bottom border above the last line.
  localparam int PADDLE_Y_MIN = BORDER;
  localparam int PADDLE_Y_MAX = LINE_COUNT - PADDLE_HEIGHT - BORDER;

endpackage

// File: rtl/paddle_pos.sv
// Paddle position from a potentiometer ADC: generates the ADC clock, averages
// blocks of samples, scales and clamps the average into a candidate top line,
// and commits the candidate to rocket_y once per frame at the vsync rise,
// ignoring changes inside the hysteresis dead-band.
module paddle_pos
  import paddle_pos_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int Y_MIN    = PADDLE_Y_MIN,
  parameter int Y_MAX    = PADDLE_Y_MAX,
  parameter int HYST     = 1
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [7:0]  adc_d,
  input  logic        vsync,
  output logic        adc_clk,
  output logic [10:0] rocket_y,
  output logic        pos_upd
);

  localparam int          SUM_W    = 8 + AVG_LOG2;
  localparam logic [10:0] Y_MIN_L  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_L  = 11'(Y_MAX);
  localparam logic [10:0] HYST_L   = 11'(HYST);

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] sample_cnt;
  logic [7:0]          avg;
  logic                avg_done;
  logic [10:0]         scaled;
  logic [10:0]         cand_next;
  logic [10:0]         candidate;
  logic                cand_valid;
  logic                vsync_q;
  logic                vsync_rise;
  logic [10:0]         diff;
  logic                strobe;
  logic                block_end;

  // A sample is taken on every edge where the ADC clock is high, i.e. every
  // second pixel clock; the last sample of a block closes the average.
  assign strobe    = adc_clk;
  assign block_end = strobe & (&sample_cnt);
  assign sum_next  = sum + SUM_W'(adc_d);

  // ADC conversion clock runs at half the pixel clock.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      adc_clk <= 1'b0;
    end else begin
      adc_clk <= ~adc_clk;
    end
  end

  // Accumulate samples; the completing sample is folded straight into the
  // average so the next block starts from a clean sum without losing data.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      sum        <= '0;
      sample_cnt <= '0;
      avg        <= '0;
      avg_done   <= 1'b0;
    end else begin
      avg_done <= block_end;
      if (strobe) begin
        sample_cnt <= sample_cnt + AVG_LOG2'(1);
        if (&sample_cnt) begin
          sum <= '0;
          avg <= sum_next[SUM_W-1:AVG_LOG2];
        end else begin
          sum <= sum_next;
        end
      end
    end
  end

  // Scale the 8-bit average to lines (x2) and clamp to the legal paddle range.
  always_comb begin
    scaled    = {2'b00, avg, 1'b0};
    cand_next = scaled;
    if (scaled < Y_MIN_L) begin
      cand_next = Y_MIN_L;
    end else if (scaled > Y_MAX_L) begin
      cand_next = Y_MAX_L;
    end
  end

  // Candidate register, loaded the cycle after a block average is ready.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      candidate  <= Y_MIN_L;
      cand_valid <= 1'b0;
    end else if (avg_done) begin
      candidate  <= cand_next;
      cand_valid <= 1'b1;
    end
  end

  // Registered copy of vsync so a held-high level yields a single rise.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign vsync_rise = vsync & ~vsync_q;

  // Distance between the pending candidate and the committed position.
  always_comb begin
    diff = '0;
    if (candidate > rocket_y) begin
      diff = candidate - rocket_y;
    end else begin
      diff = rocket_y - candidate;
    end
  end

  // Commit the candidate at the frame boundary when it moved beyond the
  // dead-band; a candidate landing in the same cycle waits for next frame
  // because the comparison uses the value held before this edge.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      rocket_y <= Y_MIN_L;
      pos_upd  <= 1'b0;
    end else begin
      pos_upd <= 1'b0;
      if (vsync_rise && cand_valid && (diff > HYST_L)) begin
        rocket_y <= candidate;
        pos_upd  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paddle_pos.sv
// Self-checking bench for paddle_pos: a frame-level reference model predicts
// each position commit into a scoreboard queue, and a monitor checks every
// pos_upd pulse and the held position against it; directed scenarios add
// constant expectations for the well-known cases.
module tb_paddle_pos;

  localparam int Y_MIN   = 8;
  localparam int Y_MAX   = 408;
  localparam int HYST    = 1;
  localparam int N_AVG   = 8;

  logic        pixel_clock;
  logic        reset;
  logic [7:0]  adc_d;
  logic        vsync;
  logic        adc_clk;
  logic [10:0] rocket_y;
  logic        pos_upd;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  int exp_q[$];

  int m_edge = 0;
  int m_samples[$];
  int m_cand = Y_MIN;
  bit m_cand_valid = 1'b0;
  int m_pend_val = 0;
  int m_pend_edge = -1;
  int m_rocket = Y_MIN;
  bit m_vs_prev = 1'b0;
  bit m_upd = 1'b0;

  paddle_pos #(
    .AVG_LOG2(3),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX),
    .HYST(HYST)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset(reset),
    .adc_d(adc_d),
    .vsync(vsync),
    .adc_clk(adc_clk),
    .rocket_y(rocket_y),
    .pos_upd(pos_upd)
  );

  // Free-running pixel clock.
  initial begin
    pixel_clock = 1'b0;
    forever #5 pixel_clock = ~pixel_clock;
  end

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic int clamp_line(input int v);
    if (v < Y_MIN) return Y_MIN;
    if (v > Y_MAX) return Y_MAX;
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: counts pixel clocks since reset, collects every second
  // one as a sample, averages each group of eight, and makes the clamped
  // result usable one edge after the block closes. A frame rise commits the
  // candidate known before that edge if it moved by more than the dead-band.
  always @(posedge pixel_clock) begin
    int s;
    if (reset) begin
      m_edge       = 0;
      m_samples.delete();
      m_cand       = Y_MIN;
      m_cand_valid = 1'b0;
      m_pend_edge  = -1;
      m_rocket     = Y_MIN;
      m_vs_prev    = 1'b0;
      m_upd        = 1'b0;
    end else begin
      m_edge++;
      m_upd = 1'b0;
      if (vsync && !m_vs_prev && m_cand_valid && abs_diff(m_cand, m_rocket) > HYST) begin
        m_rocket = m_cand;
        m_upd    = 1'b1;
        exp_q.push_back(m_rocket);
      end
      if (m_pend_edge == m_edge) begin
        m_cand       = m_pend_val;
        m_cand_valid = 1'b1;
        m_pend_edge  = -1;
      end
      if (m_edge % 2 == 0) begin
        m_samples.push_back(int'(adc_d));
        if (m_samples.size() == N_AVG) begin
          s = 0;
          foreach (m_samples[i]) s += m_samples[i];
          m_pend_val  = clamp_line((s / N_AVG) * 2);
          m_pend_edge = m_edge + 1;
          m_samples.delete();
        end
      end
      m_vs_prev = vsync;
    end
  end

  // Monitor: after each edge, compare the update pulse and position against
  // the model and pop the scoreboard on every pulse.
  initial begin
    forever begin
      @(posedge pixel_clock);
      #1;
      check_output("pos_upd_pulse", int'(pos_upd), int'(m_upd));
      if (pos_upd) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_update: got rocket_y %0d, expected no update", rocket_y);
        end else begin
          check_output("update_value", int'(rocket_y), exp_q.pop_front());
        end
      end
      check_output("rocket_y_track", int'(rocket_y), m_rocket);
      checks++;
      if (rocket_y < Y_MIN || rocket_y > Y_MAX) begin
        errors++;
        $display("[TB] FAIL rocket_y_range: got %0d, expected %0d..%0d", rocket_y, Y_MIN, Y_MAX);
      end
    end
  end

  task automatic hold(input int d, input int n);
    adc_d = 8'(d);
    repeat (n) @(negedge pixel_clock);
  endtask

  task automatic pulse_vsync(input int width);
    vsync = 1'b1;
    repeat (width) @(negedge pixel_clock);
    vsync = 1'b0;
    repeat (4) @(negedge pixel_clock);
  endtask

  task automatic apply_stimulus(input int d, input int expected_y, input int expected_pulses, input string name);
    int base;
    hold(d, 36);
    base = upd_seen;
    pulse_vsync(3);
    check_output({name, "_y"}, int'(rocket_y), expected_y);
    check_output({name, "_pulses"}, upd_seen - base, expected_pulses);
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
    int base;
    reset = 1'b1;
    adc_d = 8'd0;
    vsync = 1'b0;
    repeat (3) @(negedge pixel_clock);
    check_output("reset_rocket_y", int'(rocket_y), Y_MIN);
    check_output("reset_pos_upd", int'(pos_upd), 0);
    check_output("reset_adc_clk", int'(adc_clk), 0);
    reset = 1'b0;

    // Constant 100 for a full block, then a frame rise.
    hold(100, 20);
    base = upd_seen;
    pulse_vsync(3);
    check_output("avg100_y", int'(rocket_y), 200);
    check_output("avg100_pulses", upd_seen - base, 1);

    // Clamp at both ends, and no pulse when nothing changes.
    apply_stimulus(0, 8, 1, "low_clamp");
    apply_stimulus(255, 408, 1, "high_clamp");
    apply_stimulus(255, 408, 0, "high_repeat");

    // Dead-band: alternating 100/101 averages to 100, 101 moves by 2.
    apply_stimulus(100, 200, 1, "back_to_200");
    for (int i = 0; i < 20; i++) begin
      hold(100, 2);
      hold(101, 2);
    end
    base = upd_seen;
    pulse_vsync(3);
    check_output("deadband_y", int'(rocket_y), 200);
    check_output("deadband_pulses", upd_seen - base, 0);
    apply_stimulus(101, 202, 1, "beyond_deadband");

    // vsync held high for 1000 cycles while candidates keep changing.
    hold(50, 36);
    base = upd_seen;
    vsync = 1'b1;
    for (int i = 0; i < 25; i++) hold($urandom_range(0, 255), 40);
    vsync = 1'b0;
    check_output("long_vsync_pulses", upd_seen - base, 1);
    check_output("long_vsync_y", int'(rocket_y), 100);
    hold(50, 4);

    // Reset after 5 of 8 samples discards the partial block.
    reset = 1'b1;
    @(negedge pixel_clock);
    reset = 1'b0;
    hold(150, 10);
    reset = 1'b1;
    #1;
    check_output("midblock_reset_y", int'(rocket_y), Y_MIN);
    @(negedge pixel_clock);
    reset = 1'b0;
    hold(150, 14);
    base = upd_seen;
    pulse_vsync(2);
    check_output("no_valid_pulses", upd_seen - base, 0);
    check_output("no_valid_y", int'(rocket_y), Y_MIN);
    hold(150, 20);
    pulse_vsync(3);
    check_output("after_reset_y", int'(rocket_y), 300);

    // Candidate changes on the very edge where the rise is detected.
    reset = 1'b1;
    @(negedge pixel_clock);
    reset = 1'b0;
    hold(100, 16);
    hold(60, 16);
    vsync = 1'b1;
    @(negedge pixel_clock);
    check_output("same_cycle_old_y", int'(rocket_y), 200);
    check_output("same_cycle_pulse", int'(pos_upd), 1);
    vsync = 1'b0;
    hold(60, 20);
    pulse_vsync(3);
    check_output("same_cycle_next_frame_y", int'(rocket_y), 120);

    // Randomized frames with noisy samples and random vsync widths.
    for (int f = 0; f < 40; f++) begin
      int level;
      int len;
      level = $urandom_range(0, 255);
      len   = $urandom_range(10, 70);
      for (int c = 0; c < len; c++) begin
        int v;
        v = level + $urandom_range(0, 6) - 3;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        hold(v, 1);
      end
      pulse_vsync($urandom_range(1, 30));
    end

    repeat (5) @(negedge pixel_clock);
    check_output("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
